ecc_69_enc_pipe: RTL and testbench

ECC_69_ENC_PIPE -- requirements
Module: ecc_69_enc_pipe

---
 rtl/ecc_69_enc_pipe_if.sv | 28 ++
 rtl/ecc_69_enc_pipe.sv | 140 ++++++++++++++
 tb/tb_ecc_69_enc_pipe.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_69_enc_pipe_if.sv
// Stream bus of the SECDED write-path encoder: the accepted input beat and
// the registered, encoded output beat.
interface ecc_69_enc_pipe_if #(
    parameter int DATA_WIDTH   = 69,
    parameter int PARITY_WIDTH = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    bypass;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   data_out;
    logic [PARITY_WIDTH-1:0] parity_out;
    logic                    ecc_fault;

    // Producer of beats and consumer of the encoded result (bench or upstream logic)
    modport master (
        output in_valid, data_in, bypass, out_ready,
        input  in_ready, out_valid, data_out, parity_out, ecc_fault
    );

    // The encoder itself
    modport slave (
        input  in_valid, data_in, bypass, out_ready,
        output in_ready, out_valid, data_out, parity_out, ecc_fault
    );
endinterface

// File: rtl/ecc_69_enc_pipe.sv
// SECDED encoder for a 69-bit write path: one register stage, lockstep
// primary/shadow encoders with a saturating mismatch counter, and a one-shot
// error injector that corrupts the data after parity has been computed.

// Hamming encoder: data bit i sits at codeword position p(i), the (i+1)-th
// integer >= 3 that is not a power of two; the top bit is overall parity.
module ecc_69_enc_core #(
    parameter int DATA_WIDTH   = 69,
    parameter int PARITY_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]   data,
    output logic [PARITY_WIDTH-1:0] parity
);
    function automatic logic [PARITY_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic [PARITY_WIDTH-1:0] p;
        int unsigned             pos;
        p   = '0;
        pos = 3;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            // Powers of two are never adjacent above 2, so one skip is enough.
            if ((pos & (pos - 1)) == 0) pos = pos + 1;
            for (int k = 0; k < PARITY_WIDTH - 1; k++)
                p[k] = p[k] ^ (d[i] & pos[k]);
            pos = pos + 1;
        end
        p[PARITY_WIDTH-1] = (^d) ^ (^p[PARITY_WIDTH-2:0]);
        return p;
    endfunction

    // Purely combinational parity generation
    always_comb parity = encode(data);
endmodule

module ecc_69_enc_pipe #(
    parameter int DATA_WIDTH   = 69,
    parameter int PARITY_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ecc_69_enc_pipe_if.slave    bus,
    input  logic                ecc_fault_detc_en,
    input  logic                cmp_force,
    input  logic                inj_arm,
    input  logic [1:0]          inj_mode,
    input  logic [6:0]          inj_bit_a,
    input  logic [6:0]          inj_bit_b,
    output logic [7:0]          fault_cnt,
    output logic                inj_busy
);
    typedef enum logic {IDLE, ARMED} inj_state_t;

    inj_state_t              state, state_nxt;
    logic                    accept_p0;
    logic                    consume_p0;
    logic                    mismatch_p0;
    logic [PARITY_WIDTH-1:0] par_pri_p0;
    logic [PARITY_WIDTH-1:0] par_shd_p0;
    logic [DATA_WIDTH-1:0]   inj_mask_p0;
    logic                    vld_p1;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic [PARITY_WIDTH-1:0] par_p1;
    logic                    fault_p1;

    // ---- stage p0: combinational encode, compare and injection mask ----
    ecc_69_enc_core #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_enc_pri (
        .data   (bus.data_in),
        .parity (par_pri_p0)
    );

    ecc_69_enc_core #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_enc_shd (
        .data   (bus.data_in),
        .parity (par_shd_p0)
    );

    assign bus.in_ready = ~vld_p1 | bus.out_ready;
    assign accept_p0    = bus.in_valid & bus.in_ready;
    assign consume_p0   = accept_p0 & ~bus.bypass & (state == ARMED);
    assign mismatch_p0  = ecc_fault_detc_en &
                          (par_pri_p0 != (par_shd_p0 ^ {{(PARITY_WIDTH-1){1'b0}}, cmp_force}));
    assign inj_busy     = (state == ARMED);

    // Injection mask from the indices sampled on the consuming beat
    always_comb begin
        inj_mask_p0 = '0;
        if (consume_p0) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if ((inj_mode == 2'b01 || inj_mode == 2'b10) && inj_bit_a == 7'(i))
                    inj_mask_p0[i] = 1'b1;
                if (inj_mode == 2'b10 && inj_bit_b == 7'(i))
                    inj_mask_p0[i] = 1'b1;
            end
        end
    end

    // Injection FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Injection FSM next state: arming is ignored while already armed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (inj_arm)    state_nxt = ARMED;
            ARMED:   if (consume_p0) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // ---- stage p1: output register, held while downstream stalls ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            par_p1   <= '0;
            fault_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1   <= 1'b1;
            data_p1  <= bus.data_in ^ inj_mask_p0;
            par_p1   <= bus.bypass ? '0 : par_pri_p0;
            fault_p1 <= mismatch_p0 & ~bus.bypass;
        end else if (bus.out_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    // Saturating count of accepted, non-bypass beats whose encoders disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fault_cnt <= 8'd0;
        else if (accept_p0 && mismatch_p0 && !bus.bypass && fault_cnt != 8'hFF)
            fault_cnt <= fault_cnt + 8'd1;
    end

    assign bus.out_valid  = vld_p1;
    assign bus.data_out   = data_p1;
    assign bus.parity_out = par_p1;
    assign bus.ecc_fault  = fault_p1 & vld_p1;
endmodule

// File: tb/tb_ecc_69_enc_pipe.sv
// Directed bench for ecc_69_enc_pipe with hand-computed parity values.
module tb_ecc_69_enc_pipe;
    localparam logic [68:0] B0  = 69'h1;
    localparam logic [68:0] B1  = 69'h2;
    localparam logic [68:0] B3  = 69'h8;
    localparam logic [68:0] B68 = 69'h1 << 68;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       detc_en, cmp_force, inj_arm;
    logic [1:0] inj_mode;
    logic [6:0] inj_bit_a, inj_bit_b;
    logic [7:0] fault_cnt;
    logic       inj_busy;
    int         total = 0;
    int         passed = 0;

    ecc_69_enc_pipe_if #(.DATA_WIDTH(69), .PARITY_WIDTH(8)) bus ();

    ecc_69_enc_pipe #(.DATA_WIDTH(69), .PARITY_WIDTH(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus.slave),
        .ecc_fault_detc_en (detc_en),
        .cmp_force         (cmp_force),
        .inj_arm           (inj_arm),
        .inj_mode          (inj_mode),
        .inj_bit_a         (inj_bit_a),
        .inj_bit_b         (inj_bit_b),
        .fault_cnt         (fault_cnt),
        .inj_busy          (inj_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [68:0] d, input logic byp);
        bus.in_valid = 1'b1;
        bus.data_in  = d;
        bus.bypass   = byp;
        step();
        bus.in_valid = 1'b0;
        bus.bypass   = 1'b0;
    endtask

    task automatic arm();
        inj_arm = 1'b1;
        step();
        inj_arm = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.data_in = '0; bus.bypass = 1'b0; bus.out_ready = 1'b1;
        detc_en = 1'b0; cmp_force = 1'b0; inj_arm = 1'b0;
        inj_mode = 2'b00; inj_bit_a = 7'd0; inj_bit_b = 7'd0;
        step(); step();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); else passed++;
        total++; if (bus.data_out !== 69'h0) $display("FAIL rst_data_out got %h exp 0", bus.data_out); else passed++;
        total++; if (bus.parity_out !== 8'h00) $display("FAIL rst_parity got %h exp 00", bus.parity_out); else passed++;
        total++; if (fault_cnt !== 8'd0 || inj_busy !== 1'b0 || bus.ecc_fault !== 1'b0)
            $display("FAIL rst_ctrl got cnt=%0d busy=%b fault=%b exp 0/0/0", fault_cnt, inj_busy, bus.ecc_fault); else passed++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_encode();
        send(69'h0, 1'b0);
        total++; if (bus.out_valid !== 1'b1) $display("FAIL zero_valid got %b exp 1", bus.out_valid); else passed++;
        total++; if (bus.parity_out !== 8'h00 || bus.ecc_fault !== 1'b0)
            $display("FAIL zero_par got %h/%b exp 00/0", bus.parity_out, bus.ecc_fault); else passed++;
        send(B0, 1'b0);
        total++; if (bus.parity_out !== 8'h83 || bus.data_out !== B0)
            $display("FAIL bit0 got par=%h data=%h exp 83/%h", bus.parity_out, bus.data_out, B0); else passed++;
        send(B1, 1'b0);
        total++; if (bus.parity_out !== 8'h85) $display("FAIL bit1_par got %h exp 85", bus.parity_out); else passed++;
        send(B3, 1'b0);
        total++; if (bus.parity_out !== 8'h07) $display("FAIL bit3_par got %h exp 07", bus.parity_out); else passed++;
        send(B68, 1'b0);
        total++; if (bus.parity_out !== 8'h4C) $display("FAIL bit68_par got %h exp 4c", bus.parity_out); else passed++;
        send(B0 | B1, 1'b0);
        total++; if (bus.parity_out !== 8'h06) $display("FAIL bit01_par got %h exp 06", bus.parity_out); else passed++;
        step();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL drain_valid got %b exp 0", bus.out_valid); else passed++;
    endtask

    task automatic test_injection();
        arm();
        total++; if (inj_busy !== 1'b1) $display("FAIL inj_armed got %b exp 1", inj_busy); else passed++;
        inj_mode = 2'b10; inj_bit_a = 7'd3; inj_bit_b = 7'd68;
        send(69'h0, 1'b0);
        total++; if (bus.data_out !== (B3 | B68) || bus.parity_out !== 8'h00 || inj_busy !== 1'b0)
            $display("FAIL inj_double got data=%h par=%h busy=%b exp %h/00/0", bus.data_out, bus.parity_out, inj_busy, B3 | B68); else passed++;
        arm();
        inj_mode = 2'b01; inj_bit_a = 7'd5; inj_arm = 1'b1;
        send(B0, 1'b0);
        inj_arm = 1'b0;
        total++; if (bus.data_out !== 69'h21 || bus.parity_out !== 8'h83 || inj_busy !== 1'b0)
            $display("FAIL inj_single got data=%h par=%h busy=%b exp 21/83/0", bus.data_out, bus.parity_out, inj_busy); else passed++;
        arm();
        inj_mode = 2'b10; inj_bit_a = 7'd7; inj_bit_b = 7'd7;
        send(69'h0, 1'b0);
        total++; if (bus.data_out !== 69'h80) $display("FAIL inj_same_idx got %h exp 80", bus.data_out); else passed++;
        arm();
        inj_mode = 2'b01; inj_bit_a = 7'd100;
        send(B3, 1'b0);
        total++; if (bus.data_out !== B3 || bus.parity_out !== 8'h07 || inj_busy !== 1'b0)
            $display("FAIL inj_oob got data=%h par=%h busy=%b exp 8/07/0", bus.data_out, bus.parity_out, inj_busy); else passed++;
        arm();
        inj_mode = 2'b11; inj_bit_a = 7'd0;
        send(B0, 1'b0);
        total++; if (bus.data_out !== B0 || inj_busy !== 1'b0)
            $display("FAIL inj_mode11 got data=%h busy=%b exp 1/0", bus.data_out, inj_busy); else passed++;
        arm();
        inj_mode = 2'b01; inj_bit_a = 7'd0;
        send(B0, 1'b1);
        total++; if (bus.data_out !== B0 || bus.parity_out !== 8'h00 || inj_busy !== 1'b1)
            $display("FAIL bypass got data=%h par=%h busy=%b exp 1/00/1", bus.data_out, bus.parity_out, inj_busy); else passed++;
        send(B0, 1'b0);
        total++; if (bus.data_out !== 69'h0 || bus.parity_out !== 8'h83 || inj_busy !== 1'b0)
            $display("FAIL post_bypass got data=%h par=%h busy=%b exp 0/83/0", bus.data_out, bus.parity_out, inj_busy); else passed++;
        inj_mode = 2'b00;
        step();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        send(B0, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.data_in   = B1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.data_out !== B0 || bus.parity_out !== 8'h83)
                $display("FAIL stall_%0d got rdy=%b vld=%b data=%h par=%h exp 0/1/1/83", i, bus.in_ready, bus.out_valid, bus.data_out, bus.parity_out); else passed++;
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL release_ready got %b exp 1", bus.in_ready); else passed++;
        step();
        total++; if (bus.out_valid !== 1'b1 || bus.data_out !== B1 || bus.parity_out !== 8'h85)
            $display("FAIL b2b_first got vld=%b data=%h par=%h exp 1/2/85", bus.out_valid, bus.data_out, bus.parity_out); else passed++;
        bus.data_in = B68;
        step();
        total++; if (bus.out_valid !== 1'b1 || bus.data_out !== B68 || bus.parity_out !== 8'h4C)
            $display("FAIL b2b_second got vld=%b data=%h par=%h exp 1/%h/4c", bus.out_valid, bus.data_out, bus.parity_out, B68); else passed++;
        bus.in_valid = 1'b0;
        step();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", bus.out_valid); else passed++;
    endtask

    task automatic test_fault_count();
        detc_en = 1'b1; cmp_force = 1'b0;
        send(B1, 1'b0);
        total++; if (bus.ecc_fault !== 1'b0 || fault_cnt !== 8'd0)
            $display("FAIL no_force got fault=%b cnt=%0d exp 0/0", bus.ecc_fault, fault_cnt); else passed++;
        detc_en = 1'b0; cmp_force = 1'b1;
        send(B3, 1'b0);
        send(B0, 1'b0);
        total++; if (bus.ecc_fault !== 1'b0 || fault_cnt !== 8'd0)
            $display("FAIL detc_off got fault=%b cnt=%0d exp 0/0", bus.ecc_fault, fault_cnt); else passed++;
        detc_en = 1'b1;
        for (int n = 1; n <= 3; n++) send(69'(n), 1'b0);
        total++; if (bus.ecc_fault !== 1'b1 || fault_cnt !== 8'd3)
            $display("FAIL force_3 got fault=%b cnt=%0d exp 1/3", bus.ecc_fault, fault_cnt); else passed++;
        send(B0, 1'b1);
        total++; if (bus.ecc_fault !== 1'b0 || fault_cnt !== 8'd3 || bus.parity_out !== 8'h00)
            $display("FAIL force_bypass got fault=%b cnt=%0d par=%h exp 0/3/00", bus.ecc_fault, fault_cnt, bus.parity_out); else passed++;
        bus.in_valid = 1'b1;
        for (int n = 4; n <= 300; n++) begin
            bus.data_in = 69'(n * 7);
            step();
            total++; if (bus.ecc_fault !== 1'b1) $display("FAIL force_beat_%0d got %b exp 1", n, bus.ecc_fault); else passed++;
        end
        bus.in_valid = 1'b0;
        total++; if (fault_cnt !== 8'd255) $display("FAIL saturate got %0d exp 255", fault_cnt); else passed++;
        detc_en = 1'b0;
        send(B0, 1'b0);
        total++; if (bus.ecc_fault !== 1'b0 || fault_cnt !== 8'd255)
            $display("FAIL sat_off got fault=%b cnt=%0d exp 0/255", bus.ecc_fault, fault_cnt); else passed++;
        cmp_force = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        arm();
        send(69'h5, 1'b1);
        total++; if (bus.out_valid !== 1'b1 || inj_busy !== 1'b1)
            $display("FAIL pre_reset got vld=%b busy=%b exp 1/1", bus.out_valid, inj_busy); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.data_out !== 69'h0 || bus.parity_out !== 8'h00)
            $display("FAIL mid_rst_bus got vld=%b data=%h par=%h exp 0/0/00", bus.out_valid, bus.data_out, bus.parity_out); else passed++;
        total++; if (inj_busy !== 1'b0 || fault_cnt !== 8'd0 || bus.ecc_fault !== 1'b0)
            $display("FAIL mid_rst_ctrl got busy=%b cnt=%0d fault=%b exp 0/0/0", inj_busy, fault_cnt, bus.ecc_fault); else passed++;
        step();
        rst_n = 1'b1;
        step(); step(); step();
        total++; if (bus.out_valid !== 1'b0 || inj_busy !== 1'b0)
            $display("FAIL post_rst got vld=%b busy=%b exp 0/0", bus.out_valid, inj_busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_encode();
        test_injection();
        test_back_to_back();
        test_fault_count();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
